// File: rtl/uart_arb_pkg.sv
// Shared constants for the round-robin UART transmit arbiter and its serializer.
// State codes: the tag states are the plain frame states with bit 2 set.
package uart_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_TAG_START = 3'd5;
    localparam state_t ST_TAG_DATA  = 3'd6;
    localparam state_t ST_TAG_STOP  = 3'd7;

    localparam logic [3:0] TAG_PREFIX = 4'hA;
    localparam int         FRAME_BITS = 10;

    function automatic logic [7:0] tag_byte(input logic [1:0] id);
        return {TAG_PREFIX, 2'b00, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready byte bus; byte i occupies bits [8i+7:8i] of req_data.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4) ();

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/uart_tx_core.sv
// 8N1 serializer: load starts a frame on the next cycle, done marks the last stop-bit cycle.
// A load coinciding with done chains the next frame with no idle gap.
module uart_tx_core
    import uart_arb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output state_t     phase
);

    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);

    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    assign done = (phase == ST_STOP) && (baud == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= ST_IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (load) begin
            phase   <= ST_START;
            tx      <= 1'b0;
            baud    <= BAUD_TOP;
            bit_cnt <= '0;
            shreg   <= data;
        end else if (phase != ST_IDLE) begin
            if (baud != '0) begin
                baud <= baud - BW'(1);
            end else begin
                baud <= BAUD_TOP;
                case (phase)
                    ST_START: begin
                        phase <= ST_DATA;
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                    ST_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            phase <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                    default: begin
                        phase <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter among NUM_REQ byte requesters.
// Optional macro UART_ARB_TAG_EN prefixes each byte with a {4'hA,2'b00,grant_id} tag frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.slave         req,
    output logic                     tx,
    output logic                     busy,
    output logic [1:0]               grant_id
);

    state_t     core_phase;
    state_t     state;
    logic       core_done;
    logic       load;
    logic [7:0] load_byte;
    logic       frame_end;
    logic       found;
    logic       accept;
    logic [1:0] winner;
    logic [7:0] win_byte;

    // Search starts one past the last grant; reset leaves grant_id at NUM_REQ-1 so it starts at 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && i == (int'(grant_id) + k) % NUM_REQ && req.req_valid[i]) begin
                    found  = 1'b1;
                    winner = 2'(i);
                end
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(winner)) win_byte = req.req_data[i];
        end
    end

    assign accept = !reset && (state == ST_IDLE) && found;

    always_comb begin
        req.req_ready = '0;
        if (accept) req.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    end

`ifdef UART_ARB_TAG_EN
    logic       tag_active;
    logic [7:0] data_q;

    // The data frame is loaded on the tag frame's done so the two frames abut.
    assign load      = accept || (tag_active && core_done);
    assign load_byte = accept ? tag_byte(winner) : data_q;
    assign frame_end = core_done && !tag_active;
    assign state     = tag_active ? (core_phase | 3'b100) : core_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_active <= 1'b0;
            data_q     <= '0;
        end else if (accept) begin
            tag_active <= 1'b1;
            data_q     <= win_byte;
        end else if (core_done) begin
            tag_active <= 1'b0;
        end
    end
`else
    assign load      = accept;
    assign load_byte = win_byte;
    assign frame_end = core_done;
    assign state     = core_phase;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            grant_id <= 2'(NUM_REQ - 1);
        end else if (accept) begin
            busy     <= 1'b1;
            grant_id <= winner;
        end else if (frame_end) begin
            busy     <= 1'b0;
        end
    end

    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .data  (load_byte),
        .tx    (tx),
        .done  (core_done),
        .phase (core_phase)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a per-cycle queue model of the expected tx waveform plus round-robin grants.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NR  = 4;
    localparam int CPB = 4;
`ifdef UART_ARB_TAG_EN
    localparam int FRAMES = 2;
`else
    localparam int FRAMES = 1;
`endif
    localparam int BUSY_LEN = FRAMES * FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx;
    logic       busy;
    logic [1:0] grant_id;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.slave),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NR-1:0] pend;
    logic [7:0]    pdata [NR];
    int            m_last;
    bit            q_tx [$];
    int            grant_w;

    logic          e_tx, e_busy, o_tx, o_busy;
    logic [NR-1:0] e_ready, o_ready;
    logic [1:0]    e_gid, o_gid;

    task automatic push_frame(input logic [7:0] b);
        for (int j = 0; j < FRAME_BITS; j++)
            for (int c = 0; c < CPB; c++)
                q_tx.push_back((j == 0) ? 1'b0 : (j == FRAME_BITS - 1) ? 1'b1 : b[j-1]);
    endtask

    // One clock: drive requesters, sample the DUT, and compute what the rules say this cycle shows.
    task automatic advance();
        @(posedge clk); #1;
        bus.req_valid = pend;
        for (int i = 0; i < NR; i++) bus.req_data[i] = pdata[i];
        #1;
        cyc++;
        o_tx = tx; o_busy = busy; o_ready = bus.req_ready; o_gid = grant_id;
        e_gid = 2'(m_last); e_ready = '0; grant_w = -1;
        if (q_tx.size() > 0) begin
            e_tx = q_tx.pop_front(); e_busy = 1'b1;
        end else begin
            e_tx = 1'b1; e_busy = 1'b0;
            for (int k = 1; k <= NR; k++)
                if (grant_w < 0 && pend[(m_last + k) % NR]) grant_w = (m_last + k) % NR;
            if (grant_w >= 0) begin
                e_ready[grant_w] = 1'b1;
                m_last = grant_w;
                pend[grant_w] = 1'b0;
                if (FRAMES == 2) push_frame({TAG_PREFIX, 2'b00, 2'(grant_w)});
                push_frame(pdata[grant_w]);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; pend = '0; bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q_tx.delete(); m_last = NR - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) bus.req_data[i] = 8'($urandom);
        repeat (3) @(posedge clk); #2;
        total += 4;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset tx got=%b want=1", tx); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset ready got=%b want=0000", bus.req_ready); end
        if (grant_id !== 2'(NR - 1)) begin bad++; $display("FAIL reset grant_id got=%0d want=%0d", grant_id, NR - 1); end
        bus.req_valid = '0; pend = '0;
        @(posedge clk); #1 reset = 1'b0;
        q_tx.delete(); m_last = NR - 1;
    endtask

    task automatic test_single();
        int a = -1, rdy = 0, bcnt = 0;
        logic [FRAME_BITS-1:0] seq = '0;
        pdata[0] = 8'h55; pend = 4'b0001;
        for (int n = 0; n < BUSY_LEN + 10; n++) begin
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL single tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL single busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL single ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL single grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
            if (o_ready[0]) begin rdy++; if (a < 0) a = cyc; end
            if (o_busy) bcnt++;
            for (int j = 0; j < FRAME_BITS; j++)
                if (a >= 0 && cyc == a + 2 + CPB * ((FRAMES - 1) * FRAME_BITS + j)) seq[j] = o_tx;
        end
        total += 3;
        if (rdy != 1) begin bad++; $display("FAIL single ready_cycles got=%0d want=1", rdy); end
        if (bcnt != BUSY_LEN) begin bad++; $display("FAIL single busy_cycles got=%0d want=%0d", bcnt, BUSY_LEN); end
        if (seq !== {1'b1, 8'h55, 1'b0}) begin bad++; $display("FAIL single tx_bits got=%b want=%b", seq, {1'b1, 8'h55, 1'b0}); end
    endtask

    task automatic test_all_four();
        int gid [4];
        int gcy [4];
        int ng = 0;
        apply_reset();
        pdata[0] = 8'h10; pdata[1] = 8'h21; pdata[2] = 8'h32; pdata[3] = 8'h43;
        pend = 4'b1111;
        for (int n = 0; n < 4 * (BUSY_LEN + 1) + 10; n++) begin
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL all4 tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL all4 busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL all4 ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL all4 grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
            if (o_ready != 0 && ng < 4) begin
                for (int i = 0; i < NR; i++) if (o_ready[i]) gid[ng] = i;
                gcy[ng] = cyc; ng++;
            end
        end
        total++;
        if (ng != 4) begin
            bad++; $display("FAIL all4 grant_count got=%0d want=4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (gid[i] != i) begin bad++; $display("FAIL all4 order slot=%0d got=%0d want=%0d", i, gid[i], i); end
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (gcy[i] - gcy[i-1] != BUSY_LEN + 1) begin
                    bad++; $display("FAIL all4 spacing slot=%0d got=%0d want=%0d", i, gcy[i] - gcy[i-1], BUSY_LEN + 1);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int gid [3];
        int ng = 0;
        apply_reset();
        pdata[2] = 8'($urandom); pend = 4'b0100;
        for (int n = 0; n < 3 * (BUSY_LEN + 1) + 10; n++) begin
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL wrap tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL wrap busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL wrap ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL wrap grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
            if (o_ready != 0 && ng < 3) begin
                for (int i = 0; i < NR; i++) if (o_ready[i]) gid[ng] = i;
                ng++;
                if (ng == 1) begin
                    pdata[0] = 8'($urandom); pdata[3] = 8'($urandom);
                    pend[0] = 1'b1; pend[3] = 1'b1;
                end
            end
        end
        total++;
        if (ng != 3) begin
            bad++; $display("FAIL wrap grant_count got=%0d want=3", ng);
        end else begin
            total += 2;
            if (gid[1] != 3) begin bad++; $display("FAIL wrap first got=%0d want=3", gid[1]); end
            if (gid[2] != 0) begin bad++; $display("FAIL wrap second got=%0d want=0", gid[2]); end
        end
    endtask

    task automatic test_withdraw();
        int bsy = 0, r1 = 0, rbusy = 0;
        pdata[0] = 8'($urandom); pdata[1] = 8'($urandom); pend = 4'b0001;
        for (int n = 0; n < 2 * BUSY_LEN + 10; n++) begin
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL withdraw tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL withdraw busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL withdraw ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL withdraw grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
            if (o_busy) bsy++;
            if (bsy == 5) pend[1] = 1'b1;
            if (bsy == 15) pend[1] = 1'b0;
            if (o_ready[1]) r1++;
            if (o_busy && o_ready != 0) rbusy++;
        end
        total += 2;
        if (r1 != 0) begin bad++; $display("FAIL withdraw ready1 got=%0d want=0", r1); end
        if (rbusy != 0) begin bad++; $display("FAIL withdraw ready_while_busy got=%0d want=0", rbusy); end
    endtask

    task automatic test_reset_midframe();
        int a = -1, first = -1;
        apply_reset();
        pdata[1] = 8'($urandom); pend = 4'b0010;
        for (int n = 0; n < 5 * CPB + 8 && (a < 0 || cyc < a + 4 * CPB + 2); n++) begin
            advance();
            if (o_ready[1] && a < 0) a = cyc;
        end
        total++;
        if (a < 0) begin bad++; $display("FAIL rstmid no_grant got=0 want=1"); end
        reset = 1'b1; pend = '0; bus.req_valid = '0;
        @(posedge clk); #2;
        total += 2;
        if (tx !== 1'b1) begin bad++; $display("FAIL rstmid tx got=%b want=1", tx); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid busy got=%b want=0", busy); end
        reset = 1'b0;
        q_tx.delete(); m_last = NR - 1;
        pdata[0] = 8'($urandom); pdata[2] = 8'($urandom); pend = 4'b0101;
        for (int n = 0; n < BUSY_LEN + 10; n++) begin
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL rstmid tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL rstmid busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL rstmid ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL rstmid grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
            if (o_ready != 0 && first < 0)
                for (int i = 0; i < NR; i++) if (o_ready[i]) first = i;
        end
        total++;
        if (first != 0) begin bad++; $display("FAIL rstmid first_grant got=%0d want=0", first); end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        int a = -1, bcnt = 0;
        logic [2*FRAME_BITS-1:0] seq = '0;
        apply_reset();
        pdata[2] = 8'h3C; pend = 4'b0100;
        for (int n = 0; n < BUSY_LEN + 10; n++) begin
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL tag tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL tag busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL tag ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL tag grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
            if (o_ready[2] && a < 0) a = cyc;
            if (o_busy) bcnt++;
            for (int j = 0; j < 2 * FRAME_BITS; j++)
                if (a >= 0 && cyc == a + 2 + CPB * j) seq[j] = o_tx;
        end
        total += 2;
        if (bcnt != 80) begin bad++; $display("FAIL tag busy_cycles got=%0d want=80", bcnt); end
        if (seq !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA2, 1'b0}) begin
            bad++; $display("FAIL tag tx_bits got=%b want=%b", seq, {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA2, 1'b0});
        end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 29) == 0) begin
                    pend[i] = 1'b1; pdata[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(0, 99) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            advance();
            total += 4;
            if (o_tx !== e_tx) begin bad++; $display("FAIL random tx cyc=%0d got=%b want=%b", cyc, o_tx, e_tx); end
            if (o_busy !== e_busy) begin bad++; $display("FAIL random busy cyc=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (o_ready !== e_ready) begin bad++; $display("FAIL random ready cyc=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            if (o_gid !== e_gid) begin bad++; $display("FAIL random grant_id cyc=%0d got=%0d want=%0d", cyc, o_gid, e_gid); end
        end
    endtask

    initial begin
        pend = '0;
        for (int i = 0; i < NR; i++) pdata[i] = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        m_last = NR - 1;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_withdraw();
        test_reset_midframe();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
